// File: rtl/reg_writeback_ctrl.sv
// Write-side initiator for the register bank: arbitrates ALU/load results into an in-order
// queue drained one write per cycle. Define REG_WB_FWD_EN to enable the forwarding outputs.
module reg_writeback_ctrl #(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [DIR_WIDTH-1:0]          alu_dir,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [DIR_WIDTH-1:0]          ld_dir,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  output logic                          write_en,
  output logic [DIR_WIDTH-1:0]          write_dir,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [DIR_WIDTH-1:0]          chk_dir1,
  input  logic [DIR_WIDTH-1:0]          chk_dir2,
  output logic                          chk_pending1,
  output logic                          chk_pending2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_WIDTH-1:0]         fwd_data1,
  output logic [DATA_WIDTH-1:0]         fwd_data2,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]     FULL_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]     ZERO_OCC = {OCC_W{1'b0}};
  localparam logic [DIR_WIDTH-1:0] ZERO_DIR = {DIR_WIDTH{1'b0}};

  logic [DIR_WIDTH-1:0]  dir_mem_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  favour_alu_r;

  logic                  full_s;
  logic                  alu_fire_s;
  logic                  ld_fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DIR_WIDTH-1:0]  push_dir_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [DIR_WIDTH-1:0]  age_dir_s   [FIFO_DEPTH];
  logic                  age_valid_s [FIFO_DEPTH];
  logic                  match1_s;
  logic                  match2_s;

  assign occupancy = occ_r;

  // Round-robin arbitration on registered occupancy; dir 0 results complete without enqueueing.
  always_comb begin
    full_s     = (occ_r == FULL_OCC);
    alu_ready  = !full_s && (!ld_valid || favour_alu_r);
    ld_ready   = !full_s && (!alu_valid || !favour_alu_r);
    alu_fire_s = alu_valid && alu_ready;
    ld_fire_s  = ld_valid && ld_ready;
    if (alu_fire_s) begin
      push_dir_s  = alu_dir;
      push_data_s = alu_data;
    end else begin
      push_dir_s  = ld_dir;
      push_data_s = ld_data;
    end
    push_s = (alu_fire_s || ld_fire_s) && (push_dir_s != ZERO_DIR);
    pop_s  = (occ_r != ZERO_OCC);
  end

  // Queue storage; slots beyond occupancy are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      dir_mem_r[wr_ptr_r]  <= push_dir_s;
      data_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Pointers, occupancy, arbitration pointer and the bank write register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= ZERO_OCC;
      favour_alu_r <= 1'b0;
      write_en     <= 1'b0;
      write_dir    <= ZERO_DIR;
      write_data   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (alu_fire_s || ld_fire_s) begin
        favour_alu_r <= !favour_alu_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        write_en   <= 1'b1;
        write_dir  <= dir_mem_r[rd_ptr_r];
        write_data <= data_mem_r[rd_ptr_r];
      end else begin
        write_en <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Queue contents in age order: index 0 is the oldest entry (next to drain).
  always_comb begin
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      age_dir_s[k]   = dir_mem_r[rd_ptr_r + PTR_W'(k)];
      age_valid_s[k] = (OCC_W'(k) < occ_r);
    end
  end

  // Hazard query: queued entries plus the write currently presented to the bank.
  always_comb begin
    match1_s = write_en && (write_dir == chk_dir1);
    match2_s = write_en && (write_dir == chk_dir2);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      match1_s = match1_s | (age_valid_s[k] && (age_dir_s[k] == chk_dir1));
      match2_s = match2_s | (age_valid_s[k] && (age_dir_s[k] == chk_dir2));
    end
    chk_pending1 = match1_s && (chk_dir1 != ZERO_DIR);
    chk_pending2 = match2_s && (chk_dir2 != ZERO_DIR);
  end

`ifdef REG_WB_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_sel1_s;
  logic [DATA_WIDTH-1:0] fwd_sel2_s;

  // Youngest match wins: scan from the output register through the queue oldest-to-youngest.
  always_comb begin
    fwd_sel1_s = write_data;
    fwd_sel2_s = write_data;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_sel1_s = (age_valid_s[k] && (age_dir_s[k] == chk_dir1)) ?
                   data_mem_r[rd_ptr_r + PTR_W'(k)] : fwd_sel1_s;
      fwd_sel2_s = (age_valid_s[k] && (age_dir_s[k] == chk_dir2)) ?
                   data_mem_r[rd_ptr_r + PTR_W'(k)] : fwd_sel2_s;
    end
    fwd_hit1  = chk_pending1;
    fwd_hit2  = chk_pending2;
    fwd_data1 = chk_pending1 ? fwd_sel1_s : {DATA_WIDTH{1'b0}};
    fwd_data2 = chk_pending2 ? fwd_sel2_s : {DATA_WIDTH{1'b0}};
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = {DATA_WIDTH{1'b0}};
  assign fwd_data2 = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side initiator for the 2-read/1-write register bank.
- Accepts results from two producers (ALU and load unit) over valid/ready handshakes and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the bank's write_en/write_dir/write_data port.
- Reports per-register pending status so issue logic can stall on read-after-write hazards.

Parameters:
- DIR_WIDTH, 5, register address width; bank holds 2**DIR_WIDTH registers, register 0 hardwired zero.
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 4, writeback queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
- alu_dir  input  DIR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- ld_valid  input  1  load result valid.
- ld_ready  output  1  load result accepted this cycle when high with ld_valid.
- ld_dir  input  DIR_WIDTH  load destination register.
- ld_data  input  DATA_WIDTH  load result.
- write_en  output  1  bank write enable, registered.
- write_dir  output  DIR_WIDTH  bank write address, registered.
- write_data  output  DATA_WIDTH  bank write data, registered.
- chk_dir1  input  DIR_WIDTH  hazard query address 1.
- chk_dir2  input  DIR_WIDTH  hazard query address 2.
- chk_pending1  output  1  write to chk_dir1 still in flight (combinational).
- chk_pending2  output  1  write to chk_dir2 still in flight (combinational).
- fwd_hit1  output  1  forward data available for chk_dir1.
- fwd_hit2  output  1  forward data available for chk_dir2.
- fwd_data1  output  DATA_WIDTH  youngest in-flight value for chk_dir1.
- fwd_data2  output  DATA_WIDTH  youngest in-flight value for chk_dir2.
- occupancy  output  $clog2(FIFO_DEPTH)+1  queued entries, excluding the output register.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, pointers 0, occupancy 0, write_en/write_dir/write_data 0, arbitration pointer favours ld. Reset mid-operation discards all queued entries; no bank write occurs in the cycle after reset.
- Acceptance: at most one producer accepted per cycle.
  - Both readies are 0 when occupancy == FIFO_DEPTH; the full check uses registered occupancy, so a same-cycle pop does not free a slot.
- Round-robin arbitration: when both valids are high and space exists, grant the favoured source. The pointer flips to the other source after every grant. Single requester is always granted if not full.
  - ready outputs are combinational from valids, pointer and occupancy: alu_ready = !full && (!ld_valid || favour_alu); ld_ready = !full && (!alu_valid || !favour_alu).
- Register 0: an accepted handshake with dir == 0 completes (ready high) but is not enqueued and flips the arbitration pointer.
- Drain: if FIFO non-empty at an edge, head pops into output register; write_en=1 for exactly that cycle. If empty, write_en=0; write_dir/write_data hold.
- Latency: handshake at edge E into an empty FIFO → write_en high from E+1 to E+2 → bank captures at E+2. Sustained throughput is 1 write/cycle.
- Order: writes reach the bank in acceptance order; same-register writes keep program order.
- Push and pop in the same edge: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- chk_pendingN = 1 iff chk_dirN != 0 and it matches any valid FIFO entry or (write_en && write_dir). Entries being handshaked in the current cycle are not included.

Optional Feature:
- REG_WB_FWD_EN defined:
  - fwd_hitN = chk_pendingN.
  - fwd_dataN = data of the youngest matching entry; FIFO entries are younger than the output register.
- REG_WB_FWD_EN undefined: fwd_hit1/2 and fwd_data1/2 are tied to 0; no comparator or mux logic is generated.

Test Plan:
- Reset then alu_valid=1, alu_dir=3, alu_data=0xDEADBEEF for one cycle → alu_ready=1; write_en=1, write_dir=3, write_data=0xDEADBEEF exactly two edges after the handshake; occupancy returns to 0.
- ld_valid and alu_valid held high with distinct dirs 1..8, bank stalled-free → grants alternate ld, alu, ld, …; write sequence matches grant order; no loss.
- Block drain not possible, so fill: FIFO_DEPTH+2 back-to-back ALU results → occupancy never exceeds 4 in steady state, and alu_ready drops only when occupancy==4; all writes appear in order.
- alu_dir=0, alu_data=0x55 → alu_ready=1, occupancy stays 0, write_en stays 0.
- Queue writes r5=0x11 then r5=0x22, query chk_dir1=5 → chk_pending1=1 until the second write retires. With REG_WB_FWD_EN, fwd_data1=0x22 while both are in flight.
- rst asserted with 3 entries queued → next cycle occupancy=0, write_en=0, chk_pending1=0, and no further bank writes.
